// File: rtl/piradspi_arb_pkg.sv
// Shared types and helpers for the piradspi command arbiter.
// Optional statistics are enabled with PIRADSPI_ARB_STATS_EN.
package piradspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    XFER
  } arb_state_t;

  // Ceiling divide by a power-of-two word width, done as shift plus remainder test
  function automatic logic [31:0] xfer_words(
    input logic [31:0] len,
    input int          dw
  );
    int          sh;
    logic [31:0] m;
    sh = 0;
    for (int i = 0; i < 31; i++)
      if (dw == (1 << i)) sh = i;
    m = 32'(dw) - 32'd1;
    return (len >> sh) + {31'd0, |(len & m)};
  endfunction

  function automatic logic [31:0] xfer_len_of(
    input logic [31:0] lo,
    input int          lw
  );
    logic [31:0] m;
    m = (lw >= 32) ? '1 : ((32'd1 << lw) - 32'd1);
    return lo & m;
  endfunction

endpackage

// File: rtl/piradip_rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr, with wrap.
// No state; the caller owns the pointer.
module piradip_rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  always_comb begin
    int t;
    t     = 0;
    gnt   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      t = int'(ptr) + k;
      if (t >= N) t = t - N;
      if (!valid && req[PW'(t)]) begin
        gnt[PW'(t)] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piradspi_cmd_arbiter.sv
// Shares one piradspi engine between N_REQ clients, one transaction at a time.
// Define PIRADSPI_ARB_STATS_EN to add per-client grant_count outputs.
module piradspi_cmd_arbiter
  import piradspi_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int CMD_FIFO_WIDTH  = 72,
  parameter int DATA_FIFO_WIDTH = 32,
  parameter int XFER_LEN_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [N_REQ-1:0]                   req_cmd_tvalid,
  output logic [N_REQ-1:0]                   req_cmd_tready,
  input  logic [N_REQ*CMD_FIFO_WIDTH-1:0]    req_cmd_tdata,
  input  logic [N_REQ-1:0]                   req_mosi_tvalid,
  output logic [N_REQ-1:0]                   req_mosi_tready,
  input  logic [N_REQ*DATA_FIFO_WIDTH-1:0]   req_mosi_tdata,
  output logic [N_REQ-1:0]                   req_miso_tvalid,
  input  logic [N_REQ-1:0]                   req_miso_tready,
  output logic [DATA_FIFO_WIDTH-1:0]         req_miso_tdata,
  output logic                               eng_cmd_tvalid,
  input  logic                               eng_cmd_tready,
  output logic [CMD_FIFO_WIDTH-1:0]          eng_cmd_tdata,
  output logic                               eng_mosi_tvalid,
  input  logic                               eng_mosi_tready,
  output logic [DATA_FIFO_WIDTH-1:0]         eng_mosi_tdata,
  input  logic                               eng_miso_tvalid,
  output logic                               eng_miso_tready,
  input  logic [DATA_FIFO_WIDTH-1:0]         eng_miso_tdata,
  input  logic                               eng_cmd_completed,
  output logic [N_REQ-1:0]                   grant,
`ifdef PIRADSPI_ARB_STATS_EN
  output logic [N_REQ*32-1:0]                grant_count,
`endif
  output logic                               busy
);

  localparam int CW = CMD_FIFO_WIDTH;
  localparam int DW = DATA_FIFO_WIDTH;
  localparam int LW = XFER_LEN_WIDTH + 1;
  localparam int PW = $clog2(N_REQ);

  arb_state_t       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gidx;
  logic [LW-1:0]    mosi_left;
  logic [LW-1:0]    miso_left;
  logic [LW-1:0]    mosi_nxt;
  logic [LW-1:0]    miso_nxt;
  logic [LW-1:0]    words;
  logic             done_seen;
  logic             done_nxt;
  logic [N_REQ-1:0] arb_gnt;
  logic             arb_valid;
  logic [CW-1:0]    cmd_word;
  logic             in_cmd;
  logic             in_xfer;
  logic             mosi_on;
  logic             miso_on;
  logic             cmd_hs;
  logic             mosi_hs;
  logic             miso_hs;
  logic             fin;

  piradip_rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_cmd_tvalid),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gidx = PW'(i);
  end

  assign cmd_word = req_cmd_tdata[int'(gidx)*CW +: CW];
  assign in_cmd   = (state == CMD);
  assign in_xfer  = (state == XFER);
  assign mosi_on  = in_xfer && (|mosi_left);
  assign miso_on  = in_xfer && (|miso_left);

  // All muxes key off the registered grant, so idle/reset leaves every handshake low
  assign eng_cmd_tvalid  = in_cmd && (|(req_cmd_tvalid & grant));
  assign eng_cmd_tdata   = cmd_word;
  assign req_cmd_tready  = (in_cmd && eng_cmd_tready) ? grant : '0;
  assign eng_mosi_tvalid = mosi_on && (|(req_mosi_tvalid & grant));
  assign eng_mosi_tdata  = req_mosi_tdata[int'(gidx)*DW +: DW];
  assign req_mosi_tready = (mosi_on && eng_mosi_tready) ? grant : '0;
  assign req_miso_tvalid = (miso_on && eng_miso_tvalid) ? grant : '0;
  assign req_miso_tdata  = eng_miso_tdata;
  assign eng_miso_tready = miso_on && (|(req_miso_tready & grant));

  assign cmd_hs  = eng_cmd_tvalid && eng_cmd_tready;
  assign mosi_hs = eng_mosi_tvalid && eng_mosi_tready;
  assign miso_hs = eng_miso_tvalid && eng_miso_tready;

  assign words    = LW'(xfer_words(
                      xfer_len_of(cmd_word[31:0], XFER_LEN_WIDTH), DW));
  assign mosi_nxt = mosi_left - LW'(mosi_hs);
  assign miso_nxt = miso_left - LW'(miso_hs);
  assign done_nxt = done_seen || eng_cmd_completed;
  assign fin      = in_xfer && (mosi_nxt == '0) &&
                    (miso_nxt == '0) && done_nxt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      mosi_left <= '0;
      miso_left <= '0;
      done_seen <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            grant <= arb_gnt;
            busy  <= 1'b1;
            state <= CMD;
          end
        end
        CMD: begin
          if (cmd_hs) begin
            mosi_left <= words;
            miso_left <= words + 1'b1;
            rr_ptr    <= (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            state     <= XFER;
          end
        end
        XFER: begin
          mosi_left <= mosi_nxt;
          miso_left <= miso_nxt;
          done_seen <= done_nxt;
          if (fin) begin
            state     <= IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            done_seen <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PIRADSPI_ARB_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_count <= '0;
    end else if (fin) begin
      for (int i = 0; i < N_REQ; i++)
        if (grant[i] && (grant_count[i*32 +: 32] != '1))
          grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule
